vec_test_sequencer: RTL and testbench

- Synthesizable, parametrised vector-driven unit-test engine: the hardware successor to the file-driven per-unit testbenches.
- Holds stimulus/expected/mask vectors in internal memory and applies them to one of CHANNELS DUT ports.
- Samples each result a fixed LATENCY after stimulus, compares it under a mask, and reports pass/fail, a saturating error count and the first failing index.
- Lets the same harness check combinational units (adder, mux, extend) and registered units (flopr, regfile) on-chip.

---
 rtl/vts_pkg.sv | 31 +++
 rtl/vts_vector_mem.sv | 32 +++
 rtl/vec_test_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_vec_test_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vts_pkg.sv
// Shared types and default sizing for the vector-driven test sequencer.
//   vts_state_e : sequencer FSM states
//   vts_vec_t   : one stored vector {stim, exp, mask} at the default width
package vts_pkg;

  localparam int unsigned VTS_WIDTH    = 32;
  localparam int unsigned VTS_DEPTH    = 64;
  localparam int unsigned VTS_CHANNELS = 4;
  localparam int unsigned VTS_LATENCY  = 1;
  localparam int unsigned VTS_ERRW     = 16;

  // Address and channel-select widths for the default configuration
  localparam int unsigned VTS_AW = $clog2(VTS_DEPTH);
  localparam int unsigned VTS_CW = (VTS_CHANNELS > 1) ? $clog2(VTS_CHANNELS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } vts_state_e;

  // Memory word layout: stim in the top third, mask in the bottom third
  typedef struct packed {
    logic [VTS_WIDTH-1:0] stim;
    logic [VTS_WIDTH-1:0] exp;
    logic [VTS_WIDTH-1:0] mask;
  } vts_vec_t;

endpackage

// File: rtl/vts_vector_mem.sv
// Vector store: DEPTH x {stim, exp, mask}, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable (already qualified by the sequencer)
//   waddr : write address
//   wdata : {stim, exp, mask}
//   raddr : read address
//   rdata : {stim, exp, mask} at raddr
module vts_vector_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [3*WIDTH-1:0]   wdata,
  input  logic [AW-1:0]        raddr,
  output logic [3*WIDTH-1:0]   rdata
);

  // Contents are intentionally not reset
  logic [3*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vec_test_sequencer.sv
// Vector-driven unit-test engine. Applies stored stimulus to one DUT channel,
// samples that channel LATENCY cycles later and compares under a mask.
//   cfg_*      : vector memory write port (accepted in IDLE/DONE only)
//   num_vec    : vectors to run (clamped to DEPTH); chan_sel : target channel
//   start/abort: run control; dut_result : packed per-channel results
//   stim_out/stim_valid : stimulus and one-hot apply strobe
//   busy/done/pass/err_count/first_fail/fail_seen : run status
module vec_test_sequencer
  import vts_pkg::*;
#(
  parameter int unsigned WIDTH    = VTS_WIDTH,
  parameter int unsigned DEPTH    = VTS_DEPTH,
  parameter int unsigned CHANNELS = VTS_CHANNELS,
  parameter int unsigned LATENCY  = VTS_LATENCY,
  parameter int unsigned ERRW     = VTS_ERRW,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [WIDTH-1:0]          cfg_stim,
  input  logic [WIDTH-1:0]          cfg_exp,
  input  logic [WIDTH-1:0]          cfg_mask,
  input  logic [AW:0]               num_vec,
  input  logic [CW-1:0]             chan_sel,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHANNELS*WIDTH-1:0] dut_result,
  output logic [WIDTH-1:0]          stim_out,
  output logic [CHANNELS-1:0]       stim_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERRW-1:0]           err_count,
  output logic [AW-1:0]             first_fail,
  output logic                      fail_seen
);

  vts_state_e          state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW:0]         nvec_q, nvec_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [3:0]          wait_q, wait_d;
  logic [WIDTH-1:0]    stim_q, stim_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERRW-1:0]     err_q, err_d;
  logic [AW-1:0]       ff_q, ff_d;
  logic                fs_q, fs_d;

  logic [3*WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]    res_sel;
  logic [WIDTH-1:0]    mismatch;
  logic [AW:0]         nvec_clamp;
  logic [CW-1:0]       chan_start;
  logic                mem_we;

  // Memory is writable only while no run is in flight
  assign mem_we = cfg_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  vts_vector_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata ({cfg_stim, cfg_exp, cfg_mask}),
    .raddr (idx_d),
    .rdata (rd_data)
  );

  assign nvec_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  assign chan_start = (32'(chan_sel) >= CHANNELS) ? '0 : chan_sel;
  assign res_sel    = dut_result[32'(chan_q) * WIDTH +: WIDTH];
  assign mismatch   = (res_sel ^ exp_q) & mask_q;

  // Next-state, index, latency countdown and error bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nvec_d  = nvec_q;
    chan_d  = chan_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort && start) begin
          chan_d  = chan_start;
          nvec_d  = nvec_clamp;
          idx_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          fs_d    = 1'b0;
          state_d = (nvec_clamp == '0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (LATENCY <= 1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT;
          wait_d  = 4'(LATENCY - 2);
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wait_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (mismatch != '0) begin
            if (err_q != '1) begin
              err_d = err_q + ERRW'(1);
            end
            if (!fs_q) begin
              fs_d = 1'b1;
              ff_d = idx_q;
            end
          end
          // Compare in AW+1 bits so a full-depth run never wraps idx
          if ({1'b0, idx_q} == (nvec_q - (AW+1)'(1))) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the state being entered
  always_comb begin
    stim_d  = stim_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    valid_d = '0;
    pass_d  = pass_q;
    busy_d  = (state_d == ST_APPLY) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d  = (state_d == ST_DONE);
    if (state_d == ST_APPLY) begin
      stim_d  = rd_data[3*WIDTH-1 -: WIDTH];
      exp_d   = rd_data[2*WIDTH-1 -: WIDTH];
      mask_d  = rd_data[WIDTH-1:0];
      valid_d = CHANNELS'(1) << chan_d;
    end
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      pass_d = (err_d == '0);
    end else if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nvec_q  <= '0;
      chan_q  <= '0;
      wait_q  <= '0;
      stim_q  <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nvec_q  <= nvec_d;
      chan_q  <= chan_d;
      wait_q  <= wait_d;
      stim_q  <= stim_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  assign stim_out   = stim_q;
  assign stim_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_vec_test_sequencer.sv
// Bench for vec_test_sequencer. Three instances share the vector write port:
//   u_a : LATENCY=1, ERRW=4, channel k result = stim + k + 1
//   u_b : LATENCY=3, channel 2 = three-register pipeline on stim_out
//   u_c : LATENCY=2, same pipeline (one cycle short, so it sees the previous stim)
module tb_vec_test_sequencer;
  import vts_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_stim, cfg_exp, cfg_mask;
  logic [6:0]  num_vec;
  logic [1:0]  chan_sel;
  logic        start_a, start_b, start_c, abort_a, abort_b, abort_c;

  logic [31:0]  stim_out_a, stim_out_b, stim_out_c;
  logic [3:0]   sv_a, sv_b, sv_c;
  logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic         pass_a, pass_b, pass_c, fs_a, fs_b, fs_c;
  logic [3:0]   err_a;
  logic [15:0]  err_b, err_c;
  logic [5:0]   ff_a, ff_b, ff_c;
  logic [127:0] res_a, res_b, res_c;
  logic [31:0]  pb1, pb2, pb3, pc1, pc2, pc3;

  always #5 clk = ~clk;

  assign res_a = {stim_out_a + 32'd4, stim_out_a + 32'd3, stim_out_a + 32'd2, stim_out_a + 32'd1};
  assign res_b = {~stim_out_b, pb3, ~stim_out_b, ~stim_out_b};
  assign res_c = {~stim_out_c, pc3, ~stim_out_c, ~stim_out_c};

  // Registered DUT models: input register plus a two-flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb1 <= '0; pb2 <= '0; pb3 <= '0; pc1 <= '0; pc2 <= '0; pc3 <= '0;
    end else begin
      pb1 <= stim_out_b; pb2 <= pb1; pb3 <= pb2;
      pc1 <= stim_out_c; pc2 <= pc1; pc3 <= pc2;
    end
  end

  vec_test_sequencer #(.LATENCY(1), .ERRW(4)) u_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .num_vec(num_vec), .chan_sel(chan_sel),
    .start(start_a), .abort(abort_a), .dut_result(res_a), .stim_out(stim_out_a),
    .stim_valid(sv_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail(ff_a), .fail_seen(fs_a));

  vec_test_sequencer #(.LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .num_vec(num_vec), .chan_sel(chan_sel),
    .start(start_b), .abort(abort_b), .dut_result(res_b), .stim_out(stim_out_b),
    .stim_valid(sv_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail(ff_b), .fail_seen(fs_b));

  vec_test_sequencer #(.LATENCY(2)) u_c (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .num_vec(num_vec), .chan_sel(chan_sel),
    .start(start_c), .abort(abort_c), .dut_result(res_c), .stim_out(stim_out_c),
    .stim_valid(sv_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail(ff_c), .fail_seen(fs_c));

  typedef struct {
    logic [31:0] stim;
    logic [31:0] exp;
    logic [31:0] mask;
    int          ch;
    bit          p;
  } tv_t;

  int       n_vec = 0;
  int       n_mis = 0;
  vts_vec_t m_vec [64];
  tv_t      tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] s, input logic [31:0] e,
                    input logic [31:0] m, input bit upd);
    cfg_we = 1'b1; cfg_addr = 6'(a); cfg_stim = s; cfg_exp = e; cfg_mask = m;
    tick();
    cfg_we = 1'b0;
    if (upd) begin
      m_vec[a].stim = s; m_vec[a].exp = e; m_vec[a].mask = m;
    end
  endtask

  // Instance A run checked against a direct reading of the rules:
  // result = stim + ch + 1, n = min(nv, 64), one vector every 2 cycles.
  task automatic run_a(input string tag, input int nv, input int ch);
    int n, errs, first, cyc, sat;
    logic [31:0] r;
    n = (nv > 64) ? 64 : nv;
    errs = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      r = m_vec[i].stim + 32'(ch + 1);
      if (((r ^ m_vec[i].exp) & m_vec[i].mask) != 0) begin
        if (first < 0) first = i;
        errs++;
      end
    end
    sat = (errs > 15) ? 15 : errs;
    num_vec = 7'(nv); chan_sel = 2'(ch); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({tag, " done_cycle"}, 32'(cyc), 32'((n == 0) ? 1 : 2 * n + 1));
    chk({tag, " pass"}, 32'(pass_a), 32'(errs == 0));
    chk({tag, " err_count"}, 32'(err_a), 32'(sat));
    chk({tag, " fail_seen"}, 32'(fs_a), 32'(first >= 0));
    chk({tag, " first_fail"}, 32'(ff_a), 32'((first >= 0) ? first : 0));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, db, dc, busy_cnt, bad_sv, sv_cnt, errs, first, ch, nv, a;
    logic [31:0] s, e, m, prev;

    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_stim = '0; cfg_exp = '0; cfg_mask = '0;
    num_vec = '0; chan_sel = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
    tick(); tick();

    chk("rst stim_out", stim_out_a, 32'h0);
    chk("rst stim_valid", 32'(sv_a), 32'h0);
    chk("rst busy", 32'(busy_a), 32'h0);
    chk("rst done", 32'(done_a), 32'h0);
    chk("rst pass", 32'(pass_a), 32'h0);
    chk("rst err_count", 32'(err_a), 32'h0);
    chk("rst first_fail", 32'(ff_a), 32'h0);
    chk("rst fail_seen", 32'(fs_a), 32'h0);
    reset = 1'b1;
    tick();

    // Single-vector table: compare and mask rules across channels
    tbl[0] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b1};
    tbl[1] = '{32'hDEAD_BEEE, 32'hDEAD_0000, 32'hFFFF_0000, 0, 1'b1};
    tbl[2] = '{32'hDEAD_BEEE, 32'hDEAD_0000, 32'hFFFF_FFFF, 0, 1'b0};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFF, 1, 1'b1};
    tbl[4] = '{32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFF, 0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1};
    tbl[6] = '{32'h0000_000A, 32'h0000_0000, 32'h0000_0000, 3, 1'b1};
    tbl[7] = '{32'h0000_000A, 32'h0000_000F, 32'h0000_0001, 3, 1'b0};
    tbl[8] = '{32'h0000_0100, 32'h0000_0103, 32'hFFFF_FFFF, 2, 1'b1};
    for (int i = 0; i < 9; i++) begin
      wr(0, tbl[i].stim, tbl[i].exp, tbl[i].mask, 1'b1);
      run_a("tbl", 1, tbl[i].ch);
      chk("tbl expected pass", 32'(pass_a), 32'(tbl[i].p));
    end

    // Combinational loopback: per-cycle strobe, stimulus and done timing
    wr(0, 32'h0, 32'h1, '1, 1'b1);
    wr(1, 32'h1, 32'h2, '1, 1'b1);
    wr(2, 32'h2, 32'h3, '1, 1'b1);
    wr(3, 32'hFFFF_FFFF, 32'h0, '1, 1'b1);
    num_vec = 7'd4; chan_sel = 2'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int cc = 1; cc <= 10; cc++) begin
      chk("lb stim_valid", 32'(sv_a), ((cc <= 7) && (cc % 2 == 1)) ? 32'h1 : 32'h0);
      chk("lb done", 32'(done_a), 32'(cc == 9));
      if ((cc <= 7) && (cc % 2 == 1)) chk("lb stim_out", stim_out_a, m_vec[(cc - 1) / 2].stim);
      tick();
    end
    chk("lb pass held", 32'(pass_a), 32'h1);
    chk("lb err held", 32'(err_a), 32'h0);
    chk("lb fail_seen held", 32'(fs_a), 32'h0);

    wr(2, 32'h2, 32'h4, '1, 1'b1);
    wr(3, 32'hFFFF_FFFF, 32'h7, '1, 1'b1);
    run_a("lb2err", 4, 0);
    chk("lb2err err_count", 32'(err_a), 32'd2);
    chk("lb2err first_fail", 32'(ff_a), 32'd2);

    run_a("empty", 0, 1);

    // start and abort together in IDLE: no run
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    for (int cc = 0; cc < 4; cc++) begin
      chk("st+ab busy", 32'(busy_a), 32'h0);
      chk("st+ab done", 32'(done_a), 32'h0);
      tick();
    end
    chk("st+ab pass untouched", 32'(pass_a), 32'h1);

    // start and cfg_we while busy are ignored
    wr(2, 32'h2, 32'h3, '1, 1'b1);
    wr(3, 32'hFFFF_FFFF, 32'h0, '1, 1'b1);
    num_vec = 7'd4; chan_sel = 2'd0; start_a = 1'b1;
    tick();
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_stim = 32'h55; cfg_exp = 32'h1234; cfg_mask = '1;
    tick(); tick();
    start_a = 1'b0; cfg_we = 1'b0;
    c = 3;
    while (!done_a && c < 50) begin
      tick();
      c++;
    end
    chk("busy-ign done_cycle", 32'(c), 32'd9);
    chk("busy-ign pass", 32'(pass_a), 32'h1);
    tick();
    run_a("readback", 4, 0);

    // Saturation and clamping on the 4-bit error counter
    for (int i = 0; i < 64; i++) wr(i, 32'(i * 7), 32'(i * 7), '1, 1'b1);
    run_a("sat", 64, 0);
    chk("sat err_count", 32'(err_a), 32'd15);
    run_a("clamp", 127, 1);

    // Randomised runs against the model in run_a
    for (int r = 0; r < 25; r++) begin
      ch = $urandom_range(0, 3);
      nv = $urandom_range(0, 80);
      for (int k = 0; k < 6; k++) begin
        a = $urandom_range(0, 63);
        s = $urandom;
        e = ($urandom_range(0, 1) == 1) ? s + 32'(ch + 1) : $urandom;
        m = ($urandom_range(0, 1) == 1) ? '1 : $urandom;
        wr(a, s, e, m, 1'b1);
      end
      run_a("rand", nv, ch);
    end

    // Registered DUT: B (LATENCY=3) matches, C (LATENCY=2) sees previous stim
    for (int i = 0; i < 8; i++) begin
      s = $urandom;
      wr(i, s, s, '1, 1'b1);
    end
    num_vec = 7'd8; chan_sel = 2'd2; start_b = 1'b1; start_c = 1'b1;
    tick();
    start_b = 1'b0; start_c = 1'b0;
    c = 1; db = 0; dc = 0; busy_cnt = 0; bad_sv = 0; sv_cnt = 0;
    while (((db == 0) || (dc == 0)) && c < 100) begin
      if (busy_b) busy_cnt++;
      if ((sv_b & 4'b1011) != 0) bad_sv++;
      if (sv_b[2]) sv_cnt++;
      if (done_b) db = c;
      if (done_c) dc = c;
      tick();
      c++;
    end
    chk("reg3 busy cycles", 32'(busy_cnt), 32'd32);
    chk("reg3 other strobes", 32'(bad_sv), 32'd0);
    chk("reg3 ch2 strobes", 32'(sv_cnt), 32'd8);
    chk("reg3 done_cycle", 32'(db), 32'd33);
    chk("reg3 pass", 32'(pass_b), 32'h1);
    chk("reg3 err_count", 32'(err_b), 32'd0);
    errs = 0; first = -1; prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (m_vec[i].exp != prev) begin
        if (first < 0) first = i;
        errs++;
      end
      prev = m_vec[i].stim;
    end
    chk("reg2 done_cycle", 32'(dc), 32'd25);
    chk("reg2 err_count", 32'(err_c), 32'(errs));
    chk("reg2 first_fail", 32'(ff_c), 32'((first >= 0) ? first : 0));
    chk("reg2 pass", 32'(pass_c), 32'(errs == 0));

    // Abort in the WAIT of vector 5 on B; vectors 1 and 3 fail before that
    wr(1, m_vec[1].stim, ~m_vec[1].stim, '1, 1'b1);
    wr(3, m_vec[3].stim, ~m_vec[3].stim, '1, 1'b1);
    num_vec = 7'd8; chan_sel = 2'd2; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    c = 1;
    while (c < 21) begin
      tick();
      c++;
    end
    chk("abort v5 strobe", 32'(sv_b), 32'h4);
    tick();
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("abort busy", 32'(busy_b), 32'h0);
    chk("abort stim_valid", 32'(sv_b), 32'h0);
    db = 0;
    for (int cc = 0; cc < 12; cc++) begin
      if (done_b) db++;
      tick();
    end
    chk("abort no done", 32'(db), 32'd0);
    chk("abort pass", 32'(pass_b), 32'h0);
    chk("abort err_count", 32'(err_b), 32'd2);
    chk("abort first_fail", 32'(ff_b), 32'd1);
    chk("abort fail_seen", 32'(fs_b), 32'h1);

    // Reset mid-run clears outputs immediately
    num_vec = 7'd8; chan_sel = 2'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    chk("pre-reset busy", 32'(busy_a), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid-rst stim_out", stim_out_a, 32'h0);
    chk("mid-rst stim_valid", 32'(sv_a), 32'h0);
    chk("mid-rst busy", 32'(busy_a), 32'h0);
    chk("mid-rst done", 32'(done_a), 32'h0);
    chk("mid-rst pass", 32'(pass_a), 32'h0);
    chk("mid-rst err_count", 32'(err_a), 32'h0);
    chk("mid-rst first_fail", 32'(ff_a), 32'h0);
    chk("mid-rst fail_seen", 32'(fs_a), 32'h0);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
